// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer
// Brief    : Full-register valid/ready slice with a main/skid two-entry store.
// Revision : 1.0
// ============================================================================
module skid_buffer #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                i_ready_q;
    logic                o_valid_q;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                w_acc;
    logic                w_out;

    assign w_acc = i_valid && i_ready_q;
    assign w_out = o_valid_q && o_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (w_acc) begin
                    state_d = BUSY;
                    main_d  = i_data;
                end
            end
            BUSY: begin
                if (w_acc && !w_out) begin
                    state_d = FULL;
                    skid_d  = i_data;
                end else if (!w_acc && w_out) begin
                    state_d = EMPTY;
                end else if (w_acc && w_out) begin
                    main_d  = i_data;
                end
            end
            FULL: begin
                // i_ready is low here, so only the drain side can move.
                if (w_out) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are pure flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_ready_q <= (state_d != FULL);
            o_valid_q <= (state_d != EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = main_q;
    assign o_count = state_q;

    a_count_range : assert property (@(posedge clk) disable iff (rst) o_count != 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_buffer
// Brief    : Scenario-driven scoreboard bench for skid_buffer.
// Revision : 1.0
// ============================================================================
module tb_skid_buffer;

    localparam int DATA_W = 256;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] sb[$];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;

    skid_buffer #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: inputs change #1 after posedge, so negedge sees the
    // exact handshake values that the next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            n_cmp++;
            if (o_count === 2'd3) begin
                n_fail++;
                $display("FAIL count_range: o_count=%0d required<3", o_count);
            end
            if (prev_stall) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_stable: o_valid=%0b o_data=%0h required valid=1 data=%0h",
                             o_valid, o_data, prev_data);
                end
            end
            if (o_valid && o_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: o_data=%0h required no output", o_data);
                end else begin
                    logic [DATA_W-1:0] exp_d;
                    exp_d = sb.pop_front();
                    if (o_data !== exp_d) begin
                        n_fail++;
                        $display("FAIL sb_data: o_data=%0h required %0h", o_data, exp_d);
                    end
                end
            end
            if (i_valid && i_ready) sb.push_back(i_data);
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_data = 'hDEAD; o_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_count !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state: valid=%0b ready=%0b count=%0d required 0/1/0",
                         o_valid, i_ready, o_count);
            end
        end
        rst = 1'b0; i_data = 'h55;
        step();
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 'h55 || o_count !== 2'd1) begin
            n_fail++;
            $display("FAIL first_beat: valid=%0b data=%0h count=%0d required 1/55/1",
                     o_valid, o_data, o_count);
        end
        i_valid = 1'b0;
        step();
        n_cmp++;
        if (o_valid !== 1'b0 || o_count !== 2'd0) begin
            n_fail++;
            $display("FAIL first_drain: valid=%0b count=%0d required 0/0", o_valid, o_count);
        end
    endtask

    task automatic test_streaming();
        o_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1; i_data = k;
            step();
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== DATA_W'(k) || i_ready !== 1'b1 || o_count !== 2'd1) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%0b data=%0h ready=%0b count=%0d required 1/%0h/1/1",
                         k, o_valid, o_data, i_ready, o_count, k);
            end
        end
        i_valid = 1'b0;
        step();
        n_cmp++;
        if (o_count !== 2'd0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_empty: count=%0d valid=%0b required 0/0", o_count, o_valid);
        end
    endtask

    task automatic test_backpressure_fill();
        o_ready = 1'b0;
        i_valid = 1'b1; i_data = 'hA;
        step();
        n_cmp++;
        if (i_ready !== 1'b1 || o_count !== 2'd1 || o_data !== 'hA) begin
            n_fail++;
            $display("FAIL fill_first: ready=%0b count=%0d data=%0h required 1/1/a", i_ready, o_count, o_data);
        end
        i_data = 'hB;
        step();
        n_cmp++;
        if (i_ready !== 1'b0 || o_count !== 2'd2 || o_data !== 'hA) begin
            n_fail++;
            $display("FAIL fill_full: ready=%0b count=%0d data=%0h required 0/2/a", i_ready, o_count, o_data);
        end
        i_data = 'hC;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (i_ready !== 1'b0 || o_count !== 2'd2 || o_data !== 'hA || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_hold: ready=%0b count=%0d data=%0h valid=%0b required 0/2/a/1",
                         i_ready, o_count, o_data, o_valid);
            end
        end
    endtask

    task automatic test_drain();
        o_ready = 1'b1;
        step();
        n_cmp++;
        if (o_data !== 'hB || i_ready !== 1'b1 || o_count !== 2'd1) begin
            n_fail++;
            $display("FAIL drain_b: data=%0h ready=%0b count=%0d required b/1/1", o_data, i_ready, o_count);
        end
        step();
        n_cmp++;
        if (o_data !== 'hC || o_valid !== 1'b1 || o_count !== 2'd1) begin
            n_fail++;
            $display("FAIL drain_c: data=%0h valid=%0b count=%0d required c/1/1", o_data, o_valid, o_count);
        end
        i_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            o_ready = k[0];
            n_cmp++;
            if (o_valid !== 1'b0 || o_count !== 2'd0 || i_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL empty_toggle: valid=%0b count=%0d ready=%0b required 0/0/1",
                         o_valid, o_count, i_ready);
            end
            step();
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cycles = 0;
        int d = 1000;
        logic acc;
        i_data = d;
        while (sent < 10000 && cycles < 60000) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            #1;
            acc = i_valid && i_ready;
            step();
            cycles++;
            if (acc) begin
                sent++;
                d++;
                i_data = d;
            end
        end
        n_cmp++;
        if (sent != 10000) begin
            n_fail++;
            $display("FAIL rand_budget: sent=%0d required 10000", sent);
        end
        i_valid = 1'b0; o_ready = 1'b1;
        cycles = 0;
        while (o_count != 2'd0 && cycles < 10) begin
            step();
            cycles++;
        end
        step();
        n_cmp++;
        if (o_count !== 2'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: count=%0d pending=%0d required 0/0", o_count, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        o_ready = 1'b0;
        i_valid = 1'b1; i_data = 'h5;
        step();
        i_data = 'h6;
        step();
        i_valid = 1'b0;
        n_cmp++;
        if (o_count !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_full: count=%0d required 2", o_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_count !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%0b ready=%0b count=%0d required 0/1/0", o_valid, i_ready, o_count);
        end
        o_ready = 1'b1;
        for (int k = 0; k < 2; k++) step();
        i_valid = 1'b1; i_data = 'h7;
        step();
        i_valid = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 'h7) begin
            n_fail++;
            $display("FAIL mid_next: valid=%0b data=%0h required 1/7", o_valid, o_data);
        end
        step();
        step();
        n_cmp++;
        if (o_count !== 2'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_end: count=%0d pending=%0d required 0/0", o_count, sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure_fill();
        test_drain();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Full-register pipeline slice for valid/ready streams, W bits wide.
- The existing valid-only pipeline controller registers the forward (valid) path but leaves i_ready combinational from o_ready. This block registers the backward (ready) path as well, using a two-entry main/skid store.
- Inserted between RSA datapath stages (e.g. Montgomery core to output stage) to break long ready chains while keeping full throughput.

Parameters:
- DATA_W, 256, payload width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream data valid.
- i_ready  output  1  registered; block can accept a beat this cycle.
- i_data  input  DATA_W  upstream payload.
- o_valid  output  1  registered; o_data holds a valid beat.
- o_ready  input  1  downstream accepts a beat.
- o_data  output  DATA_W  registered payload, driven directly from the main register.
- o_count  output  2  number of stored beats (0..2), for debug/assertions.

Behaviour:
- Handshake: a beat transfers on an edge where valid && ready. Input transfer: acc = i_valid && i_ready. Output transfer: out = o_valid && o_ready.
- Storage: main register drives o_data; skid register holds the overflow beat.
- State machine: state EMPTY(0), BUSY(1), FULL(2) equals o_count.
- Registered outputs: i_ready = (state != FULL); o_valid = (state != EMPTY). Both are flops decoded from state, with no combinational path from o_ready or i_valid.
- Transitions:
  - EMPTY: acc -> BUSY, main <= i_data. No acc -> stay.
  - BUSY, acc && !out -> FULL, skid <= i_data, main unchanged.
  - BUSY, !acc && out -> EMPTY.
  - BUSY, acc && out -> BUSY, main <= i_data.
  - BUSY, neither -> stay, main unchanged.
  - FULL (i_ready=0, so i_valid is ignored): out -> BUSY, main <= skid. No out -> stay; main and skid unchanged.
- Latency: beat accepted at edge N appears on o_data/o_valid after edge N (visible in cycle N+1) when the block was EMPTY.
- Throughput: 1 beat/cycle sustained while o_ready=1.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stability: while o_valid && !o_ready, o_data and o_valid stay constant.
- i_data is sampled only on acc. The value of i_data when i_valid=0 or i_ready=0 has no effect.
- Boundary conditions:
  - In FULL, a simultaneous i_valid=1 and out: only the drain happens. The input beat is not taken because i_ready was 0 that cycle; i_ready rises the next cycle.
  - In BUSY, simultaneous acc and out: pass-through with no occupancy change.
  - o_ready toggling while EMPTY: no effect.
- Reset: rst=1 at an edge forces state=EMPTY, so o_valid=0, i_ready=1, o_count=0. This holds mid-operation; stored beats are discarded.
  - Data registers need not be reset.
  - During reset cycles, i_valid is ignored.
- Width: o_count is 2 bits; value 3 is unreachable. A verification assertion flags it.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_valid=1 -> o_valid=0, i_ready=1, o_count=0 throughout. After release, the first beat is accepted on the first edge with i_valid=1.
- Streaming: o_ready=1; send 0x1,0x2,...,0x8 back-to-back -> o_data emits 0x1..0x8 on 8 consecutive cycles, one cycle behind input; i_ready stays 1; o_count stays 1.
- Backpressure fill: o_ready=0; offer 0xA, 0xB, 0xC on consecutive cycles -> 0xA and 0xB accepted, i_ready=0 after the second accept, 0xC held upstream; o_data=0xA stable; o_count=2.
- Drain from FULL: from the previous state, set o_ready=1 -> outputs 0xA, 0xB, 0xC in order with no gap. i_ready returns to 1 one cycle after the first drain.
- Random stress: random i_valid and o_ready at 50% for 10k beats with incrementing data -> scoreboard matches exactly; o_data stable under stall; o_count never 3.
- Mid-operation reset: in FULL state (0x5, 0x6 stored), assert rst for 1 cycle -> o_valid=0, i_ready=1 next cycle. Neither 0x5 nor 0x6 is ever emitted; a subsequent beat 0x7 passes normally.
